// File: rtl/rr_grant_sel_4.sv
// rr_grant_sel_4: four-requester round-robin arbiter.
// Produces a registered 2-bit grant index plus a valid flag for the downstream
// 2-to-4 decoder. A grant is held until the owner pulses done or until it has
// been held for MAX_HOLD cycles, whichever comes first.
module rr_grant_sel_4 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_last;
    logic [7:0] r_hold_cnt;
    logic       r_grant_valid;
    logic [1:0] r_grant_idx;
    logic       r_timeout;

    logic       w_found;
    logic [1:0] w_sel;

    // Round-robin search: first set request at last+1, last+2, last+3, last (mod 4).
    always_comb begin
        logic [1:0] w_cand;
        w_found = 1'b0;
        w_sel   = r_last;
        w_cand  = r_last;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_cand = r_last + k[1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Arbiter FSM: grant from IDLE, hold in BUSY until done or hold limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last        <= 2'd3;
            r_hold_cnt    <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= 2'b00;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_idx   <= w_sel;
                        r_last        <= w_sel;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= '0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    // done has priority over an expiring hold, so no timeout pulse then.
                    if (done) begin
                        r_grant_valid <= 1'b0;
                        r_state       <= IDLE;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_grant_valid <= 1'b0;
                        r_timeout     <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_sel_4.sv
// tb_rr_grant_sel_4: directed plus random checks of rr_grant_sel_4.
// Two instances (MAX_HOLD=4 and MAX_HOLD=1) share the stimulus; a reference
// model pushes expected outputs into per-instance queues each time stimulus is
// driven, and they are popped and compared after the clock edge.
module tb_rr_grant_sel_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       v0, t0, v1, t1;
    logic [1:0] i0, i1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    rr_grant_sel_4 #(.MAX_HOLD(4)) u0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(v0), .grant_idx(i0), .timeout(t0)
    );

    rr_grant_sel_4 #(.MAX_HOLD(1)) u1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(v1), .grant_idx(i1), .timeout(t1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] i;
        logic       t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state; age counts grant cycles already shown.
    logic        m_v    [2];
    logic [1:0]  m_i    [2];
    logic [1:0]  m_last [2];
    logic        m_t    [2];
    int unsigned m_age  [2];
    int unsigned mh     [2] = '{4, 1};

    task automatic model_step(input int n);
        int unsigned c;
        bit          hit;
        if (rst) begin
            m_v[n] = 1'b0; m_i[n] = 2'd0; m_t[n] = 1'b0;
            m_last[n] = 2'd3; m_age[n] = 0;
        end else begin
            m_t[n] = 1'b0;
            if (!m_v[n]) begin
                hit = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    c = (int'(m_last[n]) + k) % 4;
                    if (!hit && req[c]) begin
                        hit = 1'b1;
                        m_i[n] = c[1:0];
                        m_last[n] = c[1:0];
                    end
                end
                if (hit) begin
                    m_v[n] = 1'b1;
                    m_age[n] = 1;
                end
            end else if (done) begin
                m_v[n] = 1'b0;
            end else if (m_age[n] >= mh[n]) begin
                m_v[n] = 1'b0;
                m_t[n] = 1'b1;
            end else begin
                m_age[n]++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, clock, then compare popped expectations.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic d);
        exp_t e;
        rst = r; req = rq; done = d;
        model_step(0);
        model_step(1);
        q0.push_back('{v: m_v[0], i: m_i[0], t: m_t[0]});
        q1.push_back('{v: m_v[1], i: m_i[1], t: m_t[1]});
        @(posedge clk);
        #1;
        e = q0.pop_front();
        check("u0.valid",   {1'b0, v0}, {1'b0, e.v});
        check("u0.idx",     i0,         e.i);
        check("u0.timeout", {1'b0, t0}, {1'b0, e.t});
        e = q1.pop_front();
        check("u1.valid",   {1'b0, v1}, {1'b0, e.v});
        check("u1.idx",     i1,         e.i);
        check("u1.timeout", {1'b0, t1}, {1'b0, e.t});
    endtask

    initial begin
        logic [1:0] exp_seq [4];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1; req = 4'b1111; done = 1'b1;

        // Reset with requests pending and done high.
        repeat (2) begin
            cyc(1'b1, 4'b1111, 1'b1);
            check("rst.valid", {1'b0, v0}, 2'd0);
            check("rst.idx",   i0,         2'd0);
            check("rst.to",    {1'b0, t0}, 2'd0);
        end
        cyc(1'b0, 4'b1111, 1'b0);
        check("first.valid", {1'b0, v0}, 2'd1);
        check("first.idx",   i0,         2'd0);

        // Full rotation with done in first grant cycle; bubble between grants.
        for (int n = 0; n < 4; n++) begin
            cyc(1'b0, 4'b1111, 1'b1);
            check("rot.bubble", {1'b0, v0}, 2'd0);
            cyc(1'b0, 4'b1111, 1'b0);
            check("rot.valid", {1'b0, v0}, 2'd1);
            check("rot.idx",   i0,         exp_seq[n]);
        end

        // Wrap and skip.
        cyc(1'b0, 4'b1111, 1'b1);
        cyc(1'b0, 4'b1111, 1'b0);
        check("wrap.idx1", i0, 2'd1);
        cyc(1'b0, 4'b0001, 1'b1);
        cyc(1'b0, 4'b0001, 1'b0);
        check("wrap.idx0", i0, 2'd0);
        cyc(1'b0, 4'b1001, 1'b1);
        cyc(1'b0, 4'b1001, 1'b0);
        check("skip.idx3", i0, 2'd3);
        cyc(1'b0, 4'b0000, 1'b1);
        // Sole requester equals last pointer: re-granted.
        cyc(1'b0, 4'b1000, 1'b0);
        check("regrant.idx", i0, 2'd3);
        check("regrant.v",   {1'b0, v0}, 2'd1);
        cyc(1'b0, 4'b0000, 1'b1);

        // Hold timeout with MAX_HOLD=4.
        cyc(1'b0, 4'b0100, 1'b0);
        check("hold.idx", i0, 2'd2);
        repeat (3) begin
            cyc(1'b0, 4'b0100, 1'b0);
            check("hold.v",  {1'b0, v0}, 2'd1);
            check("hold.to", {1'b0, t0}, 2'd0);
        end
        cyc(1'b0, 4'b0100, 1'b0);
        check("to.v",     {1'b0, v0}, 2'd0);
        check("to.pulse", {1'b0, t0}, 2'd1);
        cyc(1'b0, 4'b0100, 1'b0);
        check("to.regrant.v", {1'b0, v0}, 2'd1);
        check("to.regrant.i", i0,         2'd2);
        check("to.cleared",   {1'b0, t0}, 2'd0);

        // done coincides with the hold limit: done wins, no timeout.
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0);
        check("race.v4", {1'b0, v0}, 2'd1);
        cyc(1'b0, 4'b0100, 1'b1);
        check("race.v",  {1'b0, v0}, 2'd0);
        check("race.to", {1'b0, t0}, 2'd0);

        // Owner drops req mid-grant: grant is kept until done.
        cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0);
        check("drop.v2", {1'b0, v0}, 2'd1);
        cyc(1'b0, 4'b0000, 1'b0);
        check("drop.v3", {1'b0, v0}, 2'd1);
        cyc(1'b0, 4'b0000, 1'b1);
        check("drop.rel", {1'b0, v0}, 2'd0);
        // done in IDLE is ignored; index holds its last value.
        cyc(1'b0, 4'b0000, 1'b1);
        check("idle.done.v", {1'b0, v0}, 2'd0);
        check("idle.idx",    i0,         2'd2);

        // Reset mid-BUSY returns pointer to 3.
        cyc(1'b0, 4'b0100, 1'b0);
        check("pre.rst.idx", i0, 2'd2);
        cyc(1'b1, 4'b0100, 1'b0);
        check("midrst.v",   {1'b0, v0}, 2'd0);
        check("midrst.idx", i0,         2'd0);
        check("midrst.to",  {1'b0, t0}, 2'd0);
        cyc(1'b0, 4'b1010, 1'b0);
        check("ptr.reset.idx", i0, 2'd1);
        // Reset on the cycle the hold limit is reached cancels the timeout.
        repeat (3) cyc(1'b0, 4'b1010, 1'b0);
        cyc(1'b1, 4'b1010, 1'b0);
        check("rst.cancel.to", {1'b0, t0}, 2'd0);
        check("rst.cancel.v",  {1'b0, v0}, 2'd0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
